// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative write-back cache.
package cache_pkg;

  // Miss-handling FSM states.
  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } state_e;

  // Field width of a power-of-two quantity; zero when the field vanishes.
  function automatic int log2_w(input int n);
    return $clog2(n);
  endfunction

  // Storage width of an index into n entries; never narrower than one bit.
  function automatic int store_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_sa_wb_if.sv
// Core-side request bus and line-wide memory bus of the cache.
interface cache_sa_wb_if #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4
);
  localparam int LINE_W = LINE_WORDS * WORD_SIZE;

  logic                 c__read_m;
  logic                 c__write_m;
  logic [WORD_SIZE-1:0] c__addr;
  logic [WORD_SIZE-1:0] c__i_data;
  logic [WORD_SIZE-1:0] c__o_data;
  logic                 c__valid;

  logic                 m__read_m;
  logic                 m__write_m;
  logic [WORD_SIZE-1:0] m__addr;
  logic [LINE_W-1:0]    m__o_data;
  logic [LINE_W-1:0]    m__i_data;
  logic                 m__ready;

  // The cache: serves the core, drives the memory strobes.
  modport slave (
    input  c__read_m, c__write_m, c__addr, c__i_data, m__i_data, m__ready,
    output c__o_data, c__valid, m__read_m, m__write_m, m__addr, m__o_data
  );

  // The surrounding system: core requester plus memory model.
  modport master (
    output c__read_m, c__write_m, c__addr, c__i_data, m__i_data, m__ready,
    input  c__o_data, c__valid, m__read_m, m__write_m, m__addr, m__o_data
  );
endinterface

// File: rtl/cache_lru.sv
// True-LRU age array: one age per way per set, plus victim selection.
module cache_lru
  import cache_pkg::*;
#(
  parameter  int NUM_SETS = 2,
  parameter  int NUM_WAYS = 2,
  localparam int IDX_SW   = store_w(NUM_SETS),
  localparam int AGE_W    = store_w(NUM_WAYS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IDX_SW-1:0] set_idx,
  input  logic              access,
  input  logic [AGE_W-1:0]  access_way,
  input  logic [NUM_WAYS-1:0] valid_vec,
  output logic [AGE_W-1:0]  victim_way
);

  logic [AGE_W-1:0] age_q     [NUM_SETS][NUM_WAYS];
  logic [AGE_W-1:0] age_row_d [NUM_WAYS];
  logic [AGE_W-1:0] old_age;
  logic             any_invalid;

  // Victim: lowest-index invalid way, otherwise the oldest way.
  always_comb begin
    // NOTE: every variable gets a default first so no path can leave it unassigned and infer a latch.
    victim_way  = '0;
    any_invalid = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_vec[w]) begin
        victim_way  = AGE_W'(w);
        any_invalid = 1'b1;
      end
    end
    if (!any_invalid) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_q[set_idx][w] == AGE_W'(NUM_WAYS - 1)) victim_way = AGE_W'(w);
      end
    end
  end

  // Next ages for the accessed set: accessed way becomes 0, younger ways age by one.
  always_comb begin
    old_age = age_q[set_idx][access_way];
    for (int w = 0; w < NUM_WAYS; w++) begin
      age_row_d[w] = age_q[set_idx][w];
      if (AGE_W'(w) == access_way) begin
        age_row_d[w] = '0;
      end else if (age_q[set_idx][w] < old_age) begin
        age_row_d[w] = age_q[set_idx][w] + AGE_W'(1);
      end
    end
  end

  // Age storage: identity permutation on reset, row update on each hit.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
    if (!reset_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= AGE_W'(w);
    end else if (access) begin
      for (int w = 0; w < NUM_WAYS; w++)
        age_q[set_idx][w] <= age_row_d[w];
    end
  end

endmodule

// File: rtl/cache_sa_wb.sv
// N-way set-associative write-back, write-allocate cache with miss FSM and hit counters.
module cache_sa_wb
  import cache_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_SETS   = 2,
  parameter int NUM_WAYS   = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  cache_sa_wb_if.slave         bus,
  output logic [WORD_SIZE-1:0] num_access,
  output logic [WORD_SIZE-1:0] num_hit
);

  localparam int OFF_W  = log2_w(LINE_WORDS);
  localparam int IDX_W  = log2_w(NUM_SETS);
  localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;
  localparam int OFF_SW = store_w(LINE_WORDS);
  localparam int IDX_SW = store_w(NUM_SETS);
  localparam int WAY_SW = store_w(NUM_WAYS);
  localparam int LINE_W = LINE_WORDS * WORD_SIZE;

  // Line arrays.
  logic [LINE_W-1:0] data_q  [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
  logic              valid_q [NUM_SETS][NUM_WAYS];
  logic              dirty_q [NUM_SETS][NUM_WAYS];

  // FSM and miss context.
  state_e               state_q, state_d;
  logic [WAY_SW-1:0]    victim_q, victim_d;
  logic [IDX_SW-1:0]    miss_idx_q, miss_idx_d;
  logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
  logic                 miss_q, miss_d;
  logic                 m_read_q, m_read_d;
  logic                 m_write_q, m_write_d;
  logic [WORD_SIZE-1:0] m_addr_q, m_addr_d;
  logic [LINE_W-1:0]    m_wdata_q, m_wdata_d;
  logic [WORD_SIZE-1:0] num_access_q, num_access_d;
  logic [WORD_SIZE-1:0] num_hit_q, num_hit_d;

  logic                 req, hit_any, hit, wr_hit, fill_en, victim_dirty;
  logic [TAG_W-1:0]     req_tag;
  logic [IDX_SW-1:0]    req_idx;
  logic [OFF_SW-1:0]    req_off;
  logic [WAY_SW-1:0]    hit_way, lru_victim;
  logic [NUM_WAYS-1:0]  valid_vec;

  function automatic logic [WORD_SIZE-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                     input logic [IDX_SW-1:0] i);
    return (WORD_SIZE'(t) << (OFF_W + IDX_W)) | (WORD_SIZE'(i) << OFF_W);
  endfunction

  // Split the request address and look it up in every way of its set.
  always_comb begin
    req       = bus.c__read_m | bus.c__write_m;
    req_off   = OFF_SW'(bus.c__addr % LINE_WORDS);
    req_idx   = IDX_SW'((bus.c__addr >> OFF_W) % NUM_SETS);
    req_tag   = TAG_W'(bus.c__addr >> (OFF_W + IDX_W));
    hit_any   = 1'b0;
    hit_way   = '0;
    valid_vec = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      valid_vec[w] = valid_q[req_idx][w];
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_SW'(w);
      end
    end
    hit          = reset_n && (state_q == IDLE) && req && hit_any;
    wr_hit       = hit && bus.c__write_m;
    victim_dirty = valid_q[req_idx][lru_victim] && dirty_q[req_idx][lru_victim];
  end

  cache_lru #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_lru (
    .clk        (clk),
    .reset_n    (reset_n),
    .set_idx    (req_idx),
    .access     (hit),
    .access_way (hit_way),
    .valid_vec  (valid_vec),
    .victim_way (lru_victim)
  );

  // Miss FSM next-state, memory strobes and counters.
  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    miss_idx_d   = miss_idx_q;
    miss_tag_d   = miss_tag_q;
    miss_d       = miss_q;
    m_read_d     = m_read_q;
    m_write_d    = m_write_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    num_access_d = num_access_q;
    num_hit_d    = num_hit_q;
    fill_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          num_access_d = num_access_q + WORD_SIZE'(1);
          if (!miss_q) num_hit_d = num_hit_q + WORD_SIZE'(1);
          miss_d = 1'b0;
        end else if (req) begin
          miss_d     = 1'b1;
          victim_d   = lru_victim;
          miss_idx_d = req_idx;
          miss_tag_d = req_tag;
          m_wdata_d  = data_q[req_idx][lru_victim];
          if (victim_dirty) begin
            state_d   = WRITEBACK;
            m_write_d = 1'b1;
            m_addr_d  = line_addr(tag_q[req_idx][lru_victim], req_idx);
          end else begin
            state_d  = FILL;
            m_read_d = 1'b1;
            m_addr_d = line_addr(req_tag, req_idx);
          end
        end else begin
          // A request dropped mid-miss must not leave its flag behind.
          miss_d = 1'b0;
        end
      end
      WRITEBACK: begin
        if (bus.m__ready) begin
          state_d   = FILL;
          m_write_d = 1'b0;
          m_read_d  = 1'b1;
          m_addr_d  = line_addr(miss_tag_q, miss_idx_q);
        end
      end
      FILL: begin
        if (bus.m__ready) begin
          fill_en  = reset_n;
          state_d  = IDLE;
          m_read_d = 1'b0;
          m_addr_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, miss context, strobes and counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      victim_q     <= '0;
      miss_idx_q   <= '0;
      miss_tag_q   <= '0;
      miss_q       <= 1'b0;
      m_read_q     <= 1'b0;
      m_write_q    <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      num_access_q <= '0;
      num_hit_q    <= '0;
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      miss_idx_q   <= miss_idx_d;
      miss_tag_q   <= miss_tag_d;
      miss_q       <= miss_d;
      m_read_q     <= m_read_d;
      m_write_q    <= m_write_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      num_access_q <= num_access_d;
      num_hit_q    <= num_hit_d;
    end
  end

  // Valid and dirty bits: cleared on reset, set by fills and write hits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
        end
    end else if (fill_en) begin
      valid_q[miss_idx_q][victim_q] <= 1'b1;
      dirty_q[miss_idx_q][victim_q] <= 1'b0;
    end else if (wr_hit) begin
      dirty_q[req_idx][hit_way] <= 1'b1;
    end
  end

  // Line data and tags: installed on fill, word-merged on write hit.
  always_ff @(posedge clk) begin
    // NOTE: data and tag arrays have no reset; a line is only ever read after its valid bit is set.
    if (fill_en) begin
      data_q[miss_idx_q][victim_q] <= bus.m__i_data;
      tag_q[miss_idx_q][victim_q]  <= miss_tag_q;
    end else if (wr_hit) begin
      data_q[req_idx][hit_way][req_off*WORD_SIZE +: WORD_SIZE] <= bus.c__i_data;
    end
  end

  assign bus.c__valid  = hit;
  assign bus.c__o_data = data_q[req_idx][hit_way][req_off*WORD_SIZE +: WORD_SIZE];
  assign bus.m__read_m  = m_read_q;
  assign bus.m__write_m = m_write_q;
  assign bus.m__addr    = m_addr_q;
  assign bus.m__o_data  = m_wdata_q;
  assign num_access     = num_access_q;
  assign num_hit        = num_hit_q;

endmodule

// File: doc/cache_sa_wb.md
Name: cache_sa_wb

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data/instruction cache for the 16-bit pipelined CPU.
- Sits between the core memory stage (or IF stage) and the line-wide memory model.
- Replaces the fixed 2-way stub. Adds:
  - configurable sets, ways and line size
  - true-LRU replacement
  - dirty-line write-back
  - a miss-handling FSM
  - hit/access counters for CPI analysis

Parameters:
WORD_SIZE, 16, address and data word width in bits
NUM_SETS, 2, number of sets (power of 2, >=1)
NUM_WAYS, 2, associativity (power of 2, >=1)
LINE_WORDS, 4, words per line (power of 2, >=1); line width = LINE_WORDS*WORD_SIZE

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous active-low reset
c__read_m  in  1  core read request; held stable until c__valid
c__write_m  in  1  core write request; held stable until c__valid
c__addr  in  WORD_SIZE  word address
c__i_data  in  WORD_SIZE  store data
c__o_data  out  WORD_SIZE  load data, meaningful when c__valid & c__read_m
c__valid  out  1  request completed this cycle
m__read_m  out  1  line fill request
m__write_m  out  1  line write-back request
m__addr  out  WORD_SIZE  line-aligned address (offset bits zero)
m__o_data  out  LINE_WORDS*WORD_SIZE  write-back line data
m__i_data  in  LINE_WORDS*WORD_SIZE  fill line data
m__ready  in  1  memory completed current request this cycle
num_access  out  WORD_SIZE  completed requests, wraps at 2^WORD_SIZE
num_hit  out  WORD_SIZE  completed requests that hit without a miss, wraps

Behaviour:
- Address split, LSB first:
  - offset: log2(LINE_WORDS) bits
  - index: log2(NUM_SETS) bits
  - tag: the remaining bits
- Per line state: valid, dirty, tag, data.
- Per set state: one LRU age per way, log2(NUM_WAYS) bits wide; ages form a permutation of 0..NUM_WAYS-1.
- Reset (reset_n=0 at an edge):
  - state <= IDLE
  - all valid and dirty bits <= 0
  - age[w] <= w
  - counters <= 0
- Outputs during reset and in IDLE without a request: c__valid, m__read_m, m__write_m all 0; m__addr = 0.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE:
  - Hit = some way in the set is valid with a tag match. Hit detection is combinational.
  - On hit: c__valid = 1 in the same cycle, and c__o_data = the selected word.
  - Write hit: at the edge, the word is updated and dirty <= 1.
  - At the hit edge, LRU is updated: the hit way's age <= 0; ages smaller than its old age increment.
  - On miss: pick the victim as the lowest-index invalid way; otherwise the way with age NUM_WAYS-1.
    - Victim valid & dirty -> WRITEBACK.
    - Otherwise -> FILL.
  - No request: stay in IDLE.
- WRITEBACK:
  - m__write_m = 1, m__addr = {victim tag, index, 0}, m__o_data = victim line.
  - On m__ready -> FILL.
- FILL:
  - m__read_m = 1, m__addr = {request tag, index, 0}.
  - On m__ready, at the edge: victim line <= m__i_data, tag written, valid <= 1, dirty <= 0; then -> IDLE.
  - The request re-evaluates as a hit the following cycle and completes there.
  - That completion counts toward num_access only, not num_hit; track it with a miss flag set on the miss and cleared on completion.
- Latency:
  - hit: 0 extra cycles (same cycle)
  - clean miss: fill cycles + 1
  - dirty miss: write-back + fill + 1
- Never assert m__read_m and m__write_m together.
- m__addr and m__o_data stay stable while their strobe is high.
- Both c__read_m and c__write_m high: treat as a write.
- Request dropped mid-miss: the memory transaction still completes and the line is installed; no c__valid is raised for it.
- m__ready while in IDLE is ignored.
- Reset mid-WRITEBACK or mid-FILL: abort; strobes are 0 from the next cycle; no line is installed.
- NUM_WAYS=1: direct-mapped; LRU logic degenerates, victim is way 0.

Decomposition:
- Package cache_pkg: state enum (IDLE, WRITEBACK, FILL) and width localparams/functions (OFF_W, IDX_W, TAG_W, AGE_W via clog2).
- Sub-module cache_lru: per-set age array. Inputs: set index, access strobe, accessed way, valid vector. Outputs: victim way. Handles reset init and the age update.

Test Plan (defaults; idx = addr[2], set 0 contains 0x0010, 0x0020, 0x0030):
- Reset, then read 0x0011. Required: m__read_m with m__addr=0x0010. Memory returns line {0x4444,0x3333,0x2222,0x1111} with m__ready. Next cycle: c__valid=1, c__o_data=0x2222, num_access=1, num_hit=0.
- Read 0x0013 -> c__valid in the same cycle, o_data=0x4444, no memory strobe, num_hit=1.
- Write 0x0012 with 0xBEEF -> same-cycle c__valid, no memory traffic. Then read 0x0012 -> 0xBEEF.
- Read 0x0020 (clean fill into way 1), then read 0x0030. Required:
  - m__write_m with m__addr=0x0010 and m__o_data={0x4444,0xBEEF,0x2222,0x1111}
  - then m__read_m with m__addr=0x0030
  - then read 0x0020 hits, with no memory traffic
- Assert m__ready late (after 5 cycles) during a fill -> strobes and m__addr are held steady for all 5 cycles; exactly one completion.
- Drop reset_n during FILL -> next cycle m__read_m=0. After release, read 0x0010 misses (valid bits cleared) and counters read 0.
